// File: rtl/lisa_loader_pkg.sv
// rtl/lisa_loader_pkg.sv - shared types and constants for the imem byte-stream loader
package lisa_loader_pkg;

   // Frame parser states, in frame byte order
   typedef enum logic [2:0] {
      IDLE,
      ADDR_LO,
      ADDR_HI,
      LEN_LO,
      LEN_HI,
      DATA,
      CSUM
   } state_t;

   // err_code values reported alongside the err pulse
   localparam logic [1:0] ERR_CSUM  = 2'b01;
   localparam logic [1:0] ERR_OOB   = 2'b10;
   localparam logic [1:0] ERR_ABORT = 2'b11;

   // Default frame start marker
   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/lisa_imem_loader.sv
// rtl/lisa_imem_loader.sv - framed byte-stream loader for lisa_imem; LISA_LOADER_CHECKSUM_EN adds trailing XOR check
module lisa_imem_loader
   import lisa_loader_pkg::*;
#(
   parameter int         MEM_BYTES = 512,
   parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   input  logic        abort,
   output logic        load_we,
   output logic [15:0] load_addr,
   output logic [7:0]  load_data,
   output logic        core_hold,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code
);

   // 17 bits so a full 64 KiB memory still compares correctly against a 16-bit address
   localparam logic [16:0] MEM_LIM = 17'(MEM_BYTES);

   state_t      state, state_nx;
   logic [15:0] addr_q, addr_nx;
   logic [15:0] len_q, len_nx;
   logic        oob_q, oob_nx;
   logic        we_nx, done_nx, err_nx, hold_nx, busy_nx;
   logic [15:0] waddr_nx;
   logic [7:0]  wdata_nx;
   logic [1:0]  code_nx;
   logic        finish;
`ifdef LISA_LOADER_CHECKSUM_EN
   logic [7:0]  csum_q, csum_nx;
   logic        sum_bad;
`endif

   // The loader never stalls; only abort blocks the handshake
   assign in_ready = !abort;

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_nx = state;
      addr_nx  = addr_q;
      len_nx   = len_q;
      oob_nx   = oob_q;
      we_nx    = 1'b0;
      waddr_nx = load_addr;
      wdata_nx = load_data;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
      code_nx  = 2'b00;
      hold_nx  = core_hold;
      finish   = 1'b0;
`ifdef LISA_LOADER_CHECKSUM_EN
      csum_nx  = csum_q;
      sum_bad  = 1'b0;
`endif
      if (abort) begin
         // Abort wins over any byte offered this cycle; core stays held
         if (state != IDLE) begin
            state_nx = IDLE;
            err_nx   = 1'b1;
            code_nx  = ERR_ABORT;
         end
      end else if (in_valid) begin
`ifdef LISA_LOADER_CHECKSUM_EN
         if (state != IDLE && state != CSUM) csum_nx = csum_q ^ in_data;
`endif
         case (state)
            IDLE: begin
               if (in_data == SYNC_BYTE) begin
                  state_nx = ADDR_LO;
                  hold_nx  = 1'b1;
                  oob_nx   = 1'b0;
`ifdef LISA_LOADER_CHECKSUM_EN
                  csum_nx  = 8'h00;
`endif
               end
            end
            ADDR_LO: begin
               addr_nx[7:0] = in_data;
               state_nx     = ADDR_HI;
            end
            ADDR_HI: begin
               addr_nx[15:8] = in_data;
               state_nx      = LEN_LO;
            end
            LEN_LO: begin
               len_nx[7:0] = in_data;
               state_nx    = LEN_HI;
            end
            LEN_HI: begin
               len_nx[15:8] = in_data;
               if ({in_data, len_q[7:0]} == 16'd0) begin
`ifdef LISA_LOADER_CHECKSUM_EN
                  state_nx = CSUM;
`else
                  finish   = 1'b1;
`endif
               end else begin
                  state_nx = DATA;
               end
            end
            DATA: begin
               // Out-of-range bytes are consumed but only flagged
               if ({1'b0, addr_q} < MEM_LIM) begin
                  we_nx    = 1'b1;
                  waddr_nx = addr_q;
                  wdata_nx = in_data;
               end else begin
                  oob_nx = 1'b1;
               end
               addr_nx = addr_q + 16'd1;
               len_nx  = len_q - 16'd1;
               if (len_q == 16'd1) begin
`ifdef LISA_LOADER_CHECKSUM_EN
                  state_nx = CSUM;
`else
                  finish   = 1'b1;
`endif
               end
            end
`ifdef LISA_LOADER_CHECKSUM_EN
            CSUM: begin
               sum_bad = (in_data != csum_q);
               finish  = 1'b1;
            end
`endif
            default: state_nx = IDLE;
         endcase
      end
      if (finish) begin
         state_nx = IDLE;
`ifdef LISA_LOADER_CHECKSUM_EN
         if (sum_bad) begin
            err_nx  = 1'b1;
            code_nx = ERR_CSUM;
         end else
`endif
         if (oob_nx) begin
            err_nx  = 1'b1;
            code_nx = ERR_OOB;
         end else begin
            done_nx = 1'b1;
            hold_nx = 1'b0;
         end
      end
      busy_nx = (state_nx != IDLE);
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         addr_q    <= 16'd0;
         len_q     <= 16'd0;
         oob_q     <= 1'b0;
         load_we   <= 1'b0;
         load_addr <= 16'd0;
         load_data <= 8'd0;
         core_hold <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         err_code  <= 2'b00;
`ifdef LISA_LOADER_CHECKSUM_EN
         csum_q    <= 8'h00;
`endif
      end else begin
         state     <= state_nx;
         addr_q    <= addr_nx;
         len_q     <= len_nx;
         oob_q     <= oob_nx;
         load_we   <= we_nx;
         load_addr <= waddr_nx;
         load_data <= wdata_nx;
         core_hold <= hold_nx;
         busy      <= busy_nx;
         done      <= done_nx;
         err       <= err_nx;
         err_code  <= code_nx;
`ifdef LISA_LOADER_CHECKSUM_EN
         csum_q    <= csum_nx;
`endif
      end
   end

endmodule

// File: tb/tb_lisa_imem_loader.sv
// tb/tb_lisa_imem_loader.sv - scoreboard bench for lisa_imem_loader
module tb_lisa_imem_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        abort = 1'b0;
   logic        in_ready;
   logic        load_we;
   logic [15:0] load_addr;
   logic [7:0]  load_data;
   logic        core_hold;
   logic        busy;
   logic        done;
   logic        err;
   logic [1:0]  err_code;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int we_cnt = 0;
   int we_first = 0;
   int we_last = 0;

   logic [23:0] exp_wr[$];
   logic [7:0]  exp_ev[$];
   logic [7:0]  pl[$];

   lisa_imem_loader #(.MEM_BYTES(512), .SYNC_BYTE(8'hA5)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .abort(abort), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
      .core_hold(core_hold), .busy(busy), .done(done), .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Monitor: pops expected writes and completion events as the DUT produces them
   always @(negedge clk) begin : mon
      logic [23:0] e;
      logic [7:0]  ev;
      if (!rst) begin
         if (load_we) begin
            checks++;
            if (exp_wr.size() == 0) begin
               errors++;
               $display("FAIL write_unexpected: got %h@%h, required no write", load_data, load_addr);
            end else begin
               e = exp_wr.pop_front();
               if ({load_addr, load_data} !== e) begin
                  errors++;
                  $display("FAIL write_data: got %h@%h, required %h@%h", load_data, load_addr, e[7:0], e[23:8]);
               end
            end
            if (we_cnt == 0) we_first = cyc;
            we_last = cyc;
            we_cnt++;
         end
         if (done || err) begin
            checks++;
            ev = {2'b00, err, done, 2'b00, err ? err_code : 2'b00};
            if (exp_ev.size() == 0) begin
               errors++;
               $display("FAIL event_unexpected: got %h, required none", ev);
            end else begin
               e[7:0] = exp_ev.pop_front();
               if (ev !== e[7:0]) begin
                  errors++;
                  $display("FAIL event: got %h, required %h", ev, e[7:0]);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Sends SYNC, header, payload from pl and (when built) the checksum XOR'd with flip
   task automatic send_frame(input logic [15:0] base, input logic [7:0] flip);
      logic [7:0]  x;
      logic [15:0] len;
      logic [15:0] a;
      len = 16'(pl.size());
      x = base[7:0] ^ base[15:8] ^ len[7:0] ^ len[15:8];
      send_byte(8'hA5);
      send_byte(base[7:0]);
      send_byte(base[15:8]);
      send_byte(len[7:0]);
      send_byte(len[15:8]);
      for (int k = 0; k < pl.size(); k++) begin
         a = base + 16'(k);
         if (a < 16'd512) exp_wr.push_back({a, pl[k]});
         x = x ^ pl[k];
         send_byte(pl[k]);
      end
`ifdef LISA_LOADER_CHECKSUM_EN
      send_byte(x ^ flip);
`else
      x = x ^ flip;
`endif
   endtask

   task automatic drain_and_check(input string name);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (exp_wr.size() != 0 || exp_ev.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: pending writes=%0d events=%0d, required 0 and 0", name, exp_wr.size(), exp_ev.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({core_hold, load_we, load_addr, load_data, done, err, err_code, busy} !== {1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 2'b00, 1'b0}) begin
         errors++;
         $display("FAIL reset_outputs: got hold=%b we=%b addr=%h data=%h done=%b err=%b code=%b busy=%b, required 1 0 0000 00 0 0 00 0",
                  core_hold, load_we, load_addr, load_data, done, err, err_code, busy);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b, required 1", in_ready);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      we_cnt = 0;
      pl = '{8'h11, 8'h22, 8'h33};
      exp_ev.push_back(8'h10);
      send_frame(16'h0010, 8'h00);
      checks++;
      if ({done, busy, core_hold} !== 3'b100) begin
         errors++;
         $display("FAIL basic_complete: got done=%b busy=%b hold=%b, required 1 0 0", done, busy, core_hold);
      end
      drain_and_check("basic");
      checks++;
      if (we_cnt != 3 || (we_last - we_first) != 2) begin
         errors++;
         $display("FAIL basic_consecutive: got %0d writes over %0d cycles, required 3 over 2", we_cnt, we_last - we_first);
      end
   endtask

`ifdef LISA_LOADER_CHECKSUM_EN
   task automatic test_csum_err();
      pl = '{8'h11, 8'h22, 8'h33};
      exp_ev.push_back(8'h21);
      send_frame(16'h0010, 8'h07);
      checks++;
      if ({err, err_code, core_hold} !== 4'b1011) begin
         errors++;
         $display("FAIL csum_err: got err=%b code=%b hold=%b, required 1 01 1", err, err_code, core_hold);
      end
      drain_and_check("csum_err");
   endtask
`endif

   task automatic test_oob();
      pl = '{8'hAA, 8'hBB};
      exp_ev.push_back(8'h22);
      send_frame(16'h01FF, 8'h00);
      checks++;
      if ({err, err_code, core_hold, busy} !== 5'b11010) begin
         errors++;
         $display("FAIL oob_complete: got err=%b code=%b hold=%b busy=%b, required 1 10 1 0", err, err_code, core_hold, busy);
      end
      drain_and_check("oob");
   endtask

   task automatic test_garbage_zero_len();
      we_cnt = 0;
      send_byte(8'h00);
      send_byte(8'h7F);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL garbage_busy: got %b, required 0", busy);
      end
      pl = {};
      exp_ev.push_back(8'h10);
      send_frame(16'h0000, 8'h00);
      checks++;
      if ({done, core_hold} !== 2'b10) begin
         errors++;
         $display("FAIL zero_len_done: got done=%b hold=%b, required 1 0", done, core_hold);
      end
      drain_and_check("zero_len");
      checks++;
      if (we_cnt != 0) begin
         errors++;
         $display("FAIL zero_len_writes: got %0d, required 0", we_cnt);
      end
   endtask

   task automatic test_abort();
      send_byte(8'hA5);
      checks++;
      if ({busy, core_hold} !== 2'b11) begin
         errors++;
         $display("FAIL abort_sync_hold: got busy=%b hold=%b, required 1 1", busy, core_hold);
      end
      send_byte(8'h20);
      send_byte(8'h00);
      send_byte(8'h03);
      send_byte(8'h00);
      exp_wr.push_back({16'h0020, 8'h44});
      send_byte(8'h44);
      in_valid = 1'b1;
      in_data  = 8'h55;
      abort    = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL abort_in_ready: got %b, required 0", in_ready);
      end
      exp_ev.push_back(8'h23);
      @(posedge clk);
      #1;
      abort    = 1'b0;
      in_valid = 1'b0;
      checks++;
      if ({err, err_code, busy, core_hold} !== 5'b11101) begin
         errors++;
         $display("FAIL abort_err: got err=%b code=%b busy=%b hold=%b, required 1 11 0 1", err, err_code, busy, core_hold);
      end
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle_ignored: got err=%b, required 0", err);
      end
      pl = '{8'h66};
      exp_ev.push_back(8'h10);
      send_frame(16'h0030, 8'h00);
      checks++;
      if ({done, core_hold} !== 2'b10) begin
         errors++;
         $display("FAIL abort_fresh_frame: got done=%b hold=%b, required 1 0", done, core_hold);
      end
      drain_and_check("abort");
   endtask

   task automatic test_reset_mid();
      send_byte(8'hA5);
      send_byte(8'h40);
      send_byte(8'h00);
      send_byte(8'h04);
      send_byte(8'h00);
      exp_wr.push_back({16'h0040, 8'hC1});
      exp_wr.push_back({16'h0041, 8'hC2});
      send_byte(8'hC1);
      send_byte(8'hC2);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({core_hold, load_we, load_addr, load_data, done, err, err_code, busy} !== {1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 2'b00, 1'b0}) begin
         errors++;
         $display("FAIL reset_mid_outputs: got hold=%b we=%b addr=%h data=%h done=%b err=%b code=%b busy=%b, required 1 0 0000 00 0 0 00 0",
                  core_hold, load_we, load_addr, load_data, done, err, err_code, busy);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      pl = '{8'h01, 8'h02, 8'h03, 8'h04};
      exp_ev.push_back(8'h10);
      send_frame(16'h0050, 8'h00);
      checks++;
      if ({done, core_hold} !== 2'b10) begin
         errors++;
         $display("FAIL reset_mid_reload: got done=%b hold=%b, required 1 0", done, core_hold);
      end
      drain_and_check("reset_mid");
   endtask

   task automatic test_back_to_back();
      pl = '{8'h5A, 8'h6B};
      exp_ev.push_back(8'h10);
      send_frame(16'h0100, 8'h00);
      pl = '{8'h7C};
      exp_ev.push_back(8'h10);
      send_frame(16'h01F0, 8'h00);
      checks++;
      if ({done, core_hold, busy} !== 3'b100) begin
         errors++;
         $display("FAIL b2b_complete: got done=%b hold=%b busy=%b, required 1 0 0", done, core_hold, busy);
      end
      drain_and_check("b2b");
   endtask

   initial begin
      test_reset();
      test_basic();
`ifdef LISA_LOADER_CHECKSUM_EN
      test_csum_err();
`endif
      test_oob();
      test_garbage_zero_len();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lisa_imem_loader.md
# lisa_imem_loader

Byte-stream program loader that drives the instruction-memory loader port (`load_we`/`load_addr`/`load_data`). It receives a framed bytecode image over a valid/ready byte interface, such as a UART RX or testbench, and writes it byte-by-byte into instruction memory. While a frame is in flight it holds the LISA core in reset. It sits between the host link and `lisa_imem`, and replaces direct testbench pokes of the loader port.

## Interface
- `MEM_BYTES`, 512: instruction memory size; bytes addressed at or above it are not written.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `clk` input 1: sole clock.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: `in_data` valid.
- `in_data` input 8: stream byte.
- `in_ready` output 1: loader accepts a byte when `in_valid && in_ready`.
- `abort` input 1: synchronous; drop the current frame.
- `load_we` output 1: imem byte write strobe.
- `load_addr` output 16: imem byte address.
- `load_data` output 8: imem byte data.
- `core_hold` output 1: keep the core in reset.
- `busy` output 1: frame in progress (state ≠ IDLE).
- `done` output 1: one-cycle pulse on good frame completion.
- `err` output 1: one-cycle pulse on bad frame completion or abort.
- `err_code` output 2: valid with `err`. 01 = checksum, 10 = out-of-bounds, 11 = abort.

## Operation
- Frame format: SYNC, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, LEN payload bytes, then CSUM (CSUM only with checksum enabled).
- States and transitions:
  - IDLE → ADDR_LO → ADDR_HI → LEN_LO → LEN_HI.
  - LEN_HI → DATA, or → CSUM when LEN == 0.
  - DATA → CSUM after the LEN-th payload byte.
  - CSUM → IDLE.
  - Without checksum, CSUM is skipped; the LEN-th byte (or LEN_HI with LEN == 0) completes the frame.
- IDLE: accept and discard bytes other than SYNC_BYTE. Accepting SYNC_BYTE sets `core_hold` and enters ADDR_LO.
- DATA: each accepted byte k (0-based) is written at address base+k, truncated to 16 bits (wraps 16'hFFFF → 16'h0000).
  - Address ≥ MEM_BYTES: no write; sticky `oob` flag set; byte still consumed.
- Frame completion, in priority order:
  - Checksum mismatch: `err`, code 01.
  - Else `oob` set: `err`, code 10.
  - Else `done`, and `core_hold` cleared.
  - On any error `core_hold` stays 1.
- `abort` in any non-IDLE state: next state IDLE, `err` with code 11, `core_hold` stays 1. In IDLE, `abort` is ignored.
- `abort` has priority over a byte handshake in the same cycle; that byte is not consumed and `in_ready` is 0 that cycle.
- `in_ready` = !`abort`. The loader never stalls (imem writes are single-cycle).
- Back-to-back frames are allowed. Each new SYNC re-asserts `core_hold`.

## Timing
- Reset values: `core_hold`=1, `load_we`=0, `load_addr`=0, `load_data`=0, `done`=0, `err`=0, `err_code`=0, `busy`=0. State = IDLE, checksum = 0, `oob` = 0.
- All outputs are registered.
- Write latency: `load_we`/`load_addr`/`load_data` are valid the cycle after the payload byte is accepted. `load_we` is high for exactly one cycle per in-bounds byte.
- Payload at one byte per cycle produces `load_we` high on consecutive cycles.
- `done`/`err` pulse the cycle after the final byte (or after `abort`). `busy` falls in that same cycle.
- `core_hold` changes in the same cycle as `done`.
- Reset mid-frame: the frame is discarded immediately; no further `load_we`.

## Configuration
- `LISA_LOADER_CHECKSUM_EN` defined:
  - Running 8-bit XOR over ADDR_LO..last payload byte; cleared on SYNC.
  - The trailing CSUM byte must equal the running XOR; otherwise error code 01.
- Undefined:
  - No CSUM byte; frame ends after the payload.
  - Error code 01 is never produced; the XOR register is not built.

## Structure
- Package `lisa_loader_pkg`:
  - State enum (IDLE, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, DATA, CSUM).
  - `err_code` constants (ERR_CSUM, ERR_OOB, ERR_ABORT).
  - Default sync constant 8'hA5.
- Single module. No sub-module is warranted: the datapath is a 16-bit address counter, a 16-bit remaining-length counter and an 8-bit XOR.

## Test plan
- Checksum on: stream A5 10 00 03 00 11 22 33 13 → writes 0x11@0x0010, 0x22@0x0011, 0x33@0x0012 on consecutive cycles; `done` pulses; `core_hold` falls.
- Same frame with CSUM 0x14 → same three writes occur; `err` with code 01; `core_hold` stays 1.
- Stream A5 FF 01 02 00 AA BB with MEM_BYTES=512 (checksum off) → 0xAA written @0x01FF; no write for @0x0200; `err` code 10.
- Garbage 00 7F before A5 00 00 00 00 (checksum off) → leading bytes ignored; zero-length frame gives `done` with no `load_we`.
- `abort` asserted together with the 2nd payload byte → that byte is not consumed and not written; `err` code 11; next SYNC starts a fresh frame.
- `rst` pulsed mid-payload → all outputs return to reset values within the same cycle; a subsequent full frame loads correctly.
